pipelined_barrel_shifter: RTL and testbench

Parametrised, pipelined, multi-mode barrel shifter for the fixed-point datapath. It accepts one operand per cycle over a valid/ready handshake. It performs one of four shift modes: left with fill, right with fill, arithmetic right, or rotate left. Each binary shift level is registered, and it reports a sticky bit for alignment and rounding in the adder.

---
 rtl/pipelined_barrel_shifter_if.sv | 27 ++
 rtl/pipelined_barrel_shifter.sv | 128 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand and result valid/ready streams of the pipelined barrel shifter.
// The producer/consumer side takes the master modport, the shifter takes slave.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG   = $clog2(WIDTH)
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] In;
  logic [LOG-1:0]   ShiftAmount;
  logic             ShiftIn;
  logic [1:0]       Mode;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Out;
  logic             Sticky;

  modport master (
    output InValid, In, ShiftAmount, ShiftIn, Mode, OutReady,
    input  InReady, OutValid, Out, Sticky
  );

  modport slave (
    input  InValid, In, ShiftAmount, ShiftIn, Mode, OutReady,
    output InReady, OutValid, Out, Sticky
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: one registered binary shift level per stage,
// right shifts done as left shifts on a bit-reversed word, with a sticky flag.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned LOG  = $clog2(WIDTH)
) (
  input logic                      Clock,
  input logic                      ResetN,
  pipelined_barrel_shifter_if.slave bus
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "pipelined_barrel_shifter: WIDTH must be a power of 2 and >= 4");
  end

  localparam logic [1:0] ModeShl  = 2'b00;
  localparam logic [1:0] ModeShr  = 2'b01;
  localparam logic [1:0] ModeSra  = 2'b10;
  localparam logic [1:0] ModeRotl = 2'b11;

  function automatic logic [WIDTH-1:0] bit_rev(logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic is_right(logic [1:0] m);
    return (m == ModeShr) || (m == ModeSra);
  endfunction

  // Stage registers; amt/mode/fill are only needed by the stages that follow.
  logic [LOG-1:0][WIDTH-1:0] data_q;
  logic [LOG-1:0]            sticky_q;
  logic [LOG-1:0]            valid_q;
  logic [LOG-2:0][LOG-1:0]   amt_q;
  logic [LOG-2:0][1:0]       mode_q;
  logic [LOG-2:0]            fill_q;

  // Inputs seen by each stage's shift logic.
  logic [LOG-1:0][WIDTH-1:0] src_data;
  logic [LOG-1:0][LOG-1:0]   src_amt;
  logic [LOG-1:0][1:0]       src_mode;
  logic [LOG-1:0]            src_fill;
  logic [LOG-1:0]            src_sticky;
  logic [LOG-1:0]            src_valid;

  logic [LOG-1:0][WIDTH-1:0] nxt_data;
  logic [LOG-1:0]            nxt_sticky;

  logic stall;
  logic advance;

  assign stall       = valid_q[LOG-1] & ~bus.OutReady;
  assign advance     = ~stall;
  assign bus.InReady = ~stall;

  assign bus.OutValid = valid_q[LOG-1];
  assign bus.Out      = data_q[LOG-1];
  assign bus.Sticky   = sticky_q[LOG-1];

  always_comb begin
    src_data[0]   = is_right(bus.Mode) ? bit_rev(bus.In) : bus.In;
    src_amt[0]    = bus.ShiftAmount;
    src_mode[0]   = bus.Mode;
    src_fill[0]   = (bus.Mode == ModeSra) ? bus.In[WIDTH-1] : bus.ShiftIn;
    src_sticky[0] = 1'b0;
    src_valid[0]  = bus.InValid;
    for (int k = 1; k < LOG; k++) begin
      src_data[k]   = data_q[k-1];
      src_amt[k]    = amt_q[k-1];
      src_mode[k]   = mode_q[k-1];
      src_fill[k]   = fill_q[k-1];
      src_sticky[k] = sticky_q[k-1];
      src_valid[k]  = valid_q[k-1];
    end
  end

  for (genvar k = 0; k < LOG; k++) begin : g_stage
    localparam int unsigned Sh = 1 << k;
    logic [WIDTH-1:0] shifted;
    logic             lost;

    // Bit 0 of the remaining amount selects this level's 2^k shift.
    always_comb begin
      shifted = src_data[k];
      lost    = 1'b0;
      if (src_amt[k][0]) begin
        if (src_mode[k] == ModeRotl) begin
          shifted = {src_data[k][WIDTH-1-Sh:0], src_data[k][WIDTH-1 -: Sh]};
        end else begin
          shifted = {src_data[k][WIDTH-1-Sh:0], {Sh{src_fill[k]}}};
          lost    = |src_data[k][WIDTH-1 -: Sh];
        end
      end
    end

    if (k == LOG - 1) begin : g_last
      assign nxt_data[k] = is_right(src_mode[k]) ? bit_rev(shifted) : shifted;
    end else begin : g_mid
      assign nxt_data[k] = shifted;
    end
    assign nxt_sticky[k] = src_sticky[k] | lost;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      data_q   <= '0;
      sticky_q <= '0;
      valid_q  <= '0;
      amt_q    <= '0;
      mode_q   <= '0;
      fill_q   <= '0;
    end else if (advance) begin
      data_q   <= nxt_data;
      sticky_q <= nxt_sticky;
      valid_q  <= src_valid;
      for (int k = 0; k < LOG - 1; k++) begin
        amt_q[k]  <= src_amt[k] >> 1;
        mode_q[k] <= src_mode[k];
        fill_q[k] <= src_fill[k];
      end
    end
  end

  logic unused_mode;
  assign unused_mode = ^{ModeShl};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH = 32, five stages):
// directed cases, exhaustive pattern sweep and randomised backpressure via a scoreboard.
module tb_pipelined_barrel_shifter;
  localparam int W   = 32;
  localparam int LOG = 5;

  typedef struct packed {
    logic [W-1:0] out;
    logic         sticky;
  } res_t;

  typedef struct packed {
    logic [W-1:0]   din;
    logic [LOG-1:0] amt;
    logic [1:0]     mode;
    logic           fill;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  op_t  op_q[$];

  pipelined_barrel_shifter_if #(.WIDTH(W)) bus ();

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .Clock (clk),
    .ResetN(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic res_t model(logic [W-1:0] din, int amt, logic [1:0] mode, logic fill);
    res_t r;
    r.out    = '0;
    r.sticky = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (mode)
        2'b00:   r.out[i] = (i >= amt) ? din[i-amt] : fill;
        2'b01:   r.out[i] = (i + amt < W) ? din[i+amt] : fill;
        2'b10:   r.out[i] = (i + amt < W) ? din[i+amt] : din[W-1];
        default: r.out[i] = din[(i - amt + W) % W];
      endcase
      if (mode == 2'b00 && i >= W - amt) r.sticky |= din[i];
      if ((mode == 2'b01 || mode == 2'b10) && i < amt) r.sticky |= din[i];
    end
    return r;
  endfunction

  task automatic drive_idle();
    bus.InValid     = 1'b0;
    bus.In          = '0;
    bus.ShiftAmount = '0;
    bus.ShiftIn     = 1'b0;
    bus.Mode        = 2'b00;
    bus.OutReady    = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    drive_idle();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.OutValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid);
    end
    n_checks++;
    if (bus.InReady !== 1'b1) begin
      n_fail++; $display("FAIL reset_inready: got %b want 1", bus.InReady);
    end
    n_checks++;
    if ({bus.Out, bus.Sticky} !== '0) begin
      n_fail++; $display("FAIL reset_out: got %h/%b want 0/0", bus.Out, bus.Sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.InValid     = 1'b1;
      bus.In          = 32'hDEAD_BEEF ^ i;
      bus.ShiftAmount = 5'(i + 3);
      bus.Mode        = 2'b00;
    end
    @(negedge clk);
    bus.InValid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_prefill: got valid=%b ready=%b want 1/0", bus.OutValid, bus.InReady);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b ready=%b want 0/1", bus.OutValid, bus.InReady);
    end
    n_checks++;
    if ({bus.Out, bus.Sticky} !== '0) begin
      n_fail++; $display("FAIL reset_async_out: got %h/%b want 0/0", bus.Out, bus.Sticky);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.OutReady = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.OutValid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_stale: got %0d stale results want 0", seen);
    end
  endtask

  task automatic test_directed();
    op_t  ops [6];
    res_t want[6];
    ops[0] = '{din: 32'hFFFF_FFFF, amt: 5'd4,  mode: 2'b00, fill: 1'b0};
    ops[1] = '{din: 32'hFFFF_FFFF, amt: 5'd0,  mode: 2'b00, fill: 1'b1};
    ops[2] = '{din: 32'h0000_00F1, amt: 5'd4,  mode: 2'b01, fill: 1'b1};
    ops[3] = '{din: 32'h0000_0100, amt: 5'd8,  mode: 2'b01, fill: 1'b0};
    ops[4] = '{din: 32'h8000_0000, amt: 5'd31, mode: 2'b10, fill: 1'b0};
    ops[5] = '{din: 32'h8000_0001, amt: 5'd1,  mode: 2'b11, fill: 1'b1};
    want[0] = '{out: 32'hFFFF_FFF0, sticky: 1'b1};
    want[1] = '{out: 32'hFFFF_FFFF, sticky: 1'b0};
    want[2] = '{out: 32'hF000_000F, sticky: 1'b1};
    want[3] = '{out: 32'h0000_0001, sticky: 1'b0};
    want[4] = '{out: 32'hFFFF_FFFF, sticky: 1'b0};
    want[5] = '{out: 32'h0000_0003, sticky: 1'b0};
    for (int c = 0; c < 6; c++) begin
      int   lat;
      res_t exp;
      @(negedge clk);
      bus.InValid     = 1'b1;
      bus.In          = ops[c].din;
      bus.ShiftAmount = ops[c].amt;
      bus.Mode        = ops[c].mode;
      bus.ShiftIn     = ops[c].fill;
      bus.OutReady    = 1'b1;
      #1;
      n_checks++;
      if (bus.InReady !== 1'b1) begin
        n_fail++; $display("FAIL directed%0d_inready: got %b want 1", c, bus.InReady);
      end
      exp_q.push_back(want[c]);
      @(posedge clk);
      lat = 1;
      #1;
      bus.InValid = 1'b0;
      while (bus.OutValid !== 1'b1 && lat < 20) begin
        @(posedge clk);
        lat++;
        #1;
      end
      // Cycles counted from the accepting edge, inclusive.
      n_checks++;
      if (lat != LOG) begin
        n_fail++; $display("FAIL directed%0d_latency: got %0d cycles want %0d", c, lat, LOG);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.Out !== exp.out) begin
        n_fail++; $display("FAIL directed%0d_out: got %h want %h", c, bus.Out, exp.out);
      end
      n_checks++;
      if (bus.Sticky !== exp.sticky) begin
        n_fail++; $display("FAIL directed%0d_sticky: got %b want %b", c, bus.Sticky, exp.sticky);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [W-1:0] pats[4];
    int n, delivered, cycles, first, last, bad;
    op_t  cur;
    res_t exp;
    pats[0] = 32'h0000_0000; pats[1] = 32'hFFFF_FFFF;
    pats[2] = 32'hAAAA_AAAA; pats[3] = 32'h5555_5555;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < W; a++)
        for (int m = 0; m < 4; m++)
          for (int f = 0; f < 2; f++)
            op_q.push_back('{din: pats[p], amt: 5'(a), mode: 2'(m), fill: 1'(f)});
    n = op_q.size();
    delivered = 0; cycles = 0; first = -1; last = -1; bad = 0;
    while (delivered < n && cycles < n + 100) begin
      @(negedge clk);
      bus.OutReady = 1'b1;
      if (op_q.size() > 0) begin
        bus.InValid = 1'b1; bus.In = op_q[0].din; bus.ShiftAmount = op_q[0].amt;
        bus.Mode = op_q[0].mode; bus.ShiftIn = op_q[0].fill;
      end else begin
        bus.InValid = 1'b0;
      end
      #1;
      if (bus.InReady !== 1'b1) bad++;
      if (bus.OutValid === 1'b1 && bus.OutReady === 1'b1) begin
        if (first < 0) first = cycles;
        last = cycles;
        delivered++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sweep_spurious: got %h with nothing expected", bus.Out);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.Out, bus.Sticky} !== {exp.out, exp.sticky}) begin
            n_fail++;
            $display("FAIL sweep_result%0d: got %h/%b want %h/%b",
                     delivered - 1, bus.Out, bus.Sticky, exp.out, exp.sticky);
          end
        end
      end
      if (bus.InValid === 1'b1 && bus.InReady === 1'b1) begin
        cur = op_q.pop_front();
        exp_q.push_back(model(cur.din, int'(cur.amt), cur.mode, cur.fill));
      end
      cycles++;
    end
    bus.InValid = 1'b0;
    n_checks++;
    if (delivered != n || exp_q.size() != 0) begin
      n_fail++; $display("FAIL sweep_count: got %0d results want %0d", delivered, n);
    end
    n_checks++;
    if (last - first + 1 != n) begin
      n_fail++; $display("FAIL sweep_throughput: got %0d cycles want %0d", last - first + 1, n);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL sweep_inready: got %0d low cycles want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int n, delivered, cycles;
    logic         prev_stall;
    logic [W-1:0] prev_out;
    logic         prev_sticky;
    op_t  cur;
    res_t exp;
    n = 200;
    for (int i = 0; i < n; i++)
      op_q.push_back('{din: $urandom, amt: 5'($urandom_range(W - 1, 0)),
                       mode: 2'($urandom_range(3, 0)), fill: 1'($urandom_range(1, 0))});
    delivered = 0; cycles = 0; prev_stall = 1'b0; prev_out = '0; prev_sticky = 1'b0;
    while (delivered < n && cycles < 3000) begin
      @(negedge clk);
      bus.OutReady = 1'($urandom_range(1, 0));
      // Once offered, an operand stays on the bus until taken.
      if (bus.InValid !== 1'b1 && op_q.size() > 0 && $urandom_range(9, 0) < 7) begin
        bus.InValid = 1'b1; bus.In = op_q[0].din; bus.ShiftAmount = op_q[0].amt;
        bus.Mode = op_q[0].mode; bus.ShiftIn = op_q[0].fill;
      end
      #1;
      n_checks++;
      if (bus.InReady !== !(bus.OutValid && !bus.OutReady)) begin
        n_fail++;
        $display("FAIL bp_inready: got %b want %b", bus.InReady, !(bus.OutValid && !bus.OutReady));
      end
      if (prev_stall) begin
        n_checks++;
        if (bus.OutValid !== 1'b1 || bus.Out !== prev_out || bus.Sticky !== prev_sticky) begin
          n_fail++;
          $display("FAIL bp_stable: got %b %h/%b want 1 %h/%b",
                   bus.OutValid, bus.Out, bus.Sticky, prev_out, prev_sticky);
        end
      end
      if (bus.OutValid === 1'b1 && bus.OutReady === 1'b1) begin
        delivered++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: got %h with nothing expected", bus.Out);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.Out, bus.Sticky} !== {exp.out, exp.sticky}) begin
            n_fail++;
            $display("FAIL bp_result%0d: got %h/%b want %h/%b",
                     delivered - 1, bus.Out, bus.Sticky, exp.out, exp.sticky);
          end
        end
      end
      if (bus.InValid === 1'b1 && bus.InReady === 1'b1) begin
        cur = op_q.pop_front();
        exp_q.push_back(model(cur.din, int'(cur.amt), cur.mode, cur.fill));
        @(posedge clk);
        #1 bus.InValid = 1'b0;
      end
      prev_stall  = bus.OutValid && !bus.OutReady;
      prev_out    = bus.Out;
      prev_sticky = bus.Sticky;
      cycles++;
    end
    bus.InValid = 1'b0;
    n_checks++;
    if (delivered != n || exp_q.size() != 0 || op_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results (%0d pending) want %0d",
               delivered, exp_q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
